// File: rtl/regfile_read_port_pkg.sv
// Shared constants for the register-file read path.
//   NREG        number of registers / wordlines
//   IDW         register ID width
//   DW          register data width
//   ZERO_REG_ID register that reads as constant zero when enabled
package regfile_read_port_pkg;
  localparam int NREG        = 16;
  localparam int IDW         = 4;
  localparam int DW          = 16;
  localparam int ZERO_REG_ID = 0;
endpackage

// File: rtl/regfile_wl_decoder.sv
// One-hot wordline decoder for one read port of the register array.
// Ports:
//   i_en  decode enable (stage holds a valid request)
//   i_id  register ID to select
//   o_wl  one-hot ReadEnable wordlines, all zero when disabled or when
//         the constant-zero register is addressed
module regfile_wl_decoder #(
  parameter int NREG     = regfile_read_port_pkg::NREG,
  parameter int IDW      = regfile_read_port_pkg::IDW,
  parameter int ZERO_REG = 1
) (
  input  logic            i_en,
  input  logic [IDW-1:0]  i_id,
  output logic [NREG-1:0] o_wl
);
  import regfile_read_port_pkg::*;

  logic w_zero_hit;

  assign w_zero_hit = (ZERO_REG != 0) && (i_id == IDW'(ZERO_REG_ID));

  always_comb begin
    o_wl = '0;
    if (i_en && !w_zero_hit) begin
      o_wl[i_id] = 1'b1;
    end
  end
endmodule

// File: rtl/regfile_read_port.sv
// Read-side controller between decode and the bitline register array.
// Two-stage pipeline: S1 drives the wordlines from registered source IDs,
// S2 holds the captured operands until the consumer takes them.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   req_valid/req_ready   source-ID request handshake (src1, src2)
//   wr_en/wr_reg/wr_data  same-cycle write-back, forwarded on a match
//   ReadEnable1/2         one-hot wordlines to the array
//   Bitline1/2            shared bitline buses from the array
//   rsp_valid/rsp_ready   operand response handshake (rd_data1, rd_data2)
module regfile_read_port #(
  parameter int NREG     = regfile_read_port_pkg::NREG,
  parameter int IDW      = regfile_read_port_pkg::IDW,
  parameter int DW       = regfile_read_port_pkg::DW,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [IDW-1:0]  src1,
  input  logic [IDW-1:0]  src2,
  input  logic            wr_en,
  input  logic [IDW-1:0]  wr_reg,
  input  logic [DW-1:0]   wr_data,
  output logic [NREG-1:0] ReadEnable1,
  output logic [NREG-1:0] ReadEnable2,
  input  logic [DW-1:0]   Bitline1,
  input  logic [DW-1:0]   Bitline2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rd_data1,
  output logic [DW-1:0]   rd_data2
);
  import regfile_read_port_pkg::*;

  logic           r_s1_valid;
  logic [IDW-1:0] r_s1_src1;
  logic [IDW-1:0] r_s1_src2;
  logic           r_rsp_valid;
  logic [DW-1:0]  r_rd_data1;
  logic [DW-1:0]  r_rd_data2;

  logic           w_s1_adv;
  logic           w_req_ready;
  logic [DW-1:0]  w_cap1;
  logic [DW-1:0]  w_cap2;

  // Operand selection: constant zero, then write-back forwarding (the array
  // only updates at the edge, so its bitline is one write behind), then bus.
  function automatic logic [DW-1:0] f_capture(
    input logic [IDW-1:0] src,
    input logic           we,
    input logic [IDW-1:0] wreg,
    input logic [DW-1:0]  wdata,
    input logic [DW-1:0]  bitline
  );
    logic zero_hit;
    zero_hit = (ZERO_REG != 0) && (src == IDW'(ZERO_REG_ID));
    if (zero_hit) begin
      f_capture = '0;
    end else if (we && (wreg == src)) begin
      f_capture = wdata;
    end else begin
      f_capture = bitline;
    end
  endfunction

  assign w_s1_adv    = r_s1_valid && (!r_rsp_valid || rsp_ready);
  assign w_req_ready = !r_s1_valid || w_s1_adv;
  assign w_cap1      = f_capture(r_s1_src1, wr_en, wr_reg, wr_data, Bitline1);
  assign w_cap2      = f_capture(r_s1_src2, wr_en, wr_reg, wr_data, Bitline2);

  // Decoders see only registered state, so the wordlines do not glitch
  // with upstream request activity.
  regfile_wl_decoder #(
    .NREG     (NREG),
    .IDW      (IDW),
    .ZERO_REG (ZERO_REG)
  ) u_wl_dec1 (
    .i_en (r_s1_valid),
    .i_id (r_s1_src1),
    .o_wl (ReadEnable1)
  );

  regfile_wl_decoder #(
    .NREG     (NREG),
    .IDW      (IDW),
    .ZERO_REG (ZERO_REG)
  ) u_wl_dec2 (
    .i_en (r_s1_valid),
    .i_id (r_s1_src2),
    .o_wl (ReadEnable2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_src1   <= '0;
      r_s1_src2   <= '0;
      r_rsp_valid <= 1'b0;
      r_rd_data1  <= '0;
      r_rd_data2  <= '0;
    end else begin
      if (req_valid && w_req_ready) begin
        r_s1_valid <= 1'b1;
        r_s1_src1  <= src1;
        r_s1_src2  <= src2;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      // S2 is a snapshot: data only changes when a new request advances in.
      if (w_s1_adv) begin
        r_rsp_valid <= 1'b1;
        r_rd_data1  <= w_cap1;
        r_rd_data2  <= w_cap2;
      end else if (r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rd_data1  = r_rd_data1;
  assign rd_data2  = r_rd_data2;
endmodule
